// File: rtl/lsu.sv
// Load/store unit: takes one memory operation at a time from the EXU, checks
// its alignment, runs a single-outstanding bus transaction, and returns
// formatted load data to the GPR file as a one-cycle writeback pulse.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Valid, once raised, keeps its payload stable until that edge.
// Ready may depend on state but never on the partner's valid.
//   lsu_rx_*  : EXU -> LSU, accepted only while IDLE.
//   dbus_req_*: LSU -> bus, one request per operation.
//   dbus_rsp_*: bus -> LSU, single-beat response, only observed in RSP.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_rx_valid,
    output logic        lsu_rx_ready,
    input  logic        lsu_rx_is_load,
    input  logic        lsu_rx_is_store,
    input  logic [2:0]  lsu_rx_funct3,
    input  logic [31:0] lsu_rx_addr,
    input  logic [31:0] lsu_rx_wdata,
    input  logic [4:0]  lsu_rx_rd_idx,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic [31:0] dbus_req_addr,
    output logic        dbus_req_we,
    output logic [3:0]  dbus_req_wstrb,
    output logic [31:0] dbus_req_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rsp_rdata,
    output logic [31:0] lsu_tx_mem,
    output logic        lsu_tx_mem_valid,
    output logic [4:0]  lsu_tx_rd_idx,
    output logic        lsu_tx_fault,
    output logic [31:0] lsu_tx_fault_addr,
    output logic        lsu_tx_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RSP   = 3'd2,
        ST_WB    = 3'd3,
        ST_FAULT = 3'd4
    } lsu_state_t;

    lsu_state_t state_q;
    lsu_state_t state_d;

    // Latched operation attributes needed after the accept edge.
    logic       ld_q;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic [4:0] rd_q;

    // Next values of the registered control outputs.
    logic ready_d;
    logic req_valid_d;
    logic mem_valid_d;
    logic fault_d;
    logic busy_d;

    logic        accept;
    logic        rx_fault;
    logic        kind_bad;
    logic        f3_bad;
    logic        misaligned;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata;
    logic [31:0] lane;
    logic [31:0] load_fmt;

    // Ready is the registered output, so nothing is accepted in the first
    // cycle after reset even though the state is already IDLE.
    assign accept = (state_q == ST_IDLE) && lsu_rx_valid && lsu_rx_ready;

    // Classify the incoming operation: bad kind, bad funct3 or misalignment.
    always_comb begin
        kind_bad   = (lsu_rx_is_load == lsu_rx_is_store);
        f3_bad     = 1'b0;
        misaligned = 1'b0;
        if (lsu_rx_is_load) begin
            f3_bad = !(lsu_rx_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            f3_bad = !(lsu_rx_funct3 inside {3'b000, 3'b001, 3'b010});
        end
        // funct3[1:0] encodes access size for every legal encoding.
        if (lsu_rx_funct3[1:0] == 2'b01) begin
            misaligned = lsu_rx_addr[0];
        end else if (lsu_rx_funct3[1:0] == 2'b10) begin
            misaligned = (lsu_rx_addr[1:0] != 2'b00);
        end
        rx_fault = kind_bad || f3_bad || misaligned;
    end

    // Store byte enables and lane-replicated data; loads request no bytes.
    always_comb begin
        fmt_wstrb = 4'b0000;
        fmt_wdata = 32'h0;
        if (lsu_rx_is_store) begin
            case (lsu_rx_funct3[1:0])
                2'b00: begin
                    fmt_wstrb = 4'b0001 << lsu_rx_addr[1:0];
                    fmt_wdata = {4{lsu_rx_wdata[7:0]}};
                end
                2'b01: begin
                    fmt_wstrb = lsu_rx_addr[1] ? 4'b1100 : 4'b0011;
                    fmt_wdata = {2{lsu_rx_wdata[15:0]}};
                end
                default: begin
                    fmt_wstrb = 4'b1111;
                    fmt_wdata = lsu_rx_wdata;
                end
            endcase
        end
    end

    // Shift the addressed bytes down to bit 0 and extend to 32 bits.
    always_comb begin
        lane     = dbus_rsp_rdata >> {off_q, 3'b000};
        load_fmt = dbus_rsp_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'h0, lane[7:0]};
            3'b101:  load_fmt = {16'h0, lane[15:0]};
            default: load_fmt = dbus_rsp_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = rx_fault ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                if (dbus_req_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (dbus_rsp_valid) begin
                    state_d = ld_q ? ST_WB : ST_IDLE;
                end
            end
            ST_WB:    state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control outputs are a function of the state being entered, so they can
    // be registered alongside the state and still line up with it.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        req_valid_d = (state_d == ST_REQ);
        mem_valid_d = (state_d == ST_WB);
        fault_d     = (state_d == ST_FAULT);
        busy_d      = (state_d != ST_IDLE);
    end

    // Register the control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_rx_ready     <= 1'b0;
            dbus_req_valid   <= 1'b0;
            lsu_tx_mem_valid <= 1'b0;
            lsu_tx_fault     <= 1'b0;
            lsu_tx_busy      <= 1'b0;
        end else begin
            lsu_rx_ready     <= ready_d;
            dbus_req_valid   <= req_valid_d;
            lsu_tx_mem_valid <= mem_valid_d;
            lsu_tx_fault     <= fault_d;
            lsu_tx_busy      <= busy_d;
        end
    end

    // Latch the operation on accept and capture formatted load data on the
    // response; request fields therefore stay put while the bus stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q              <= 1'b0;
            f3_q              <= 3'b000;
            off_q             <= 2'b00;
            rd_q              <= 5'd0;
            dbus_req_addr     <= 32'h0;
            dbus_req_we       <= 1'b0;
            dbus_req_wstrb    <= 4'b0000;
            dbus_req_wdata    <= 32'h0;
            lsu_tx_fault_addr <= 32'h0;
            lsu_tx_mem        <= 32'h0;
            lsu_tx_rd_idx     <= 5'd0;
        end else begin
            if (accept) begin
                ld_q  <= lsu_rx_is_load;
                f3_q  <= lsu_rx_funct3;
                off_q <= lsu_rx_addr[1:0];
                rd_q  <= lsu_rx_rd_idx;
                if (rx_fault) begin
                    lsu_tx_fault_addr <= lsu_rx_addr;
                end else begin
                    dbus_req_addr  <= {lsu_rx_addr[31:2], 2'b00};
                    dbus_req_we    <= lsu_rx_is_store;
                    dbus_req_wstrb <= fmt_wstrb;
                    dbus_req_wdata <= fmt_wdata;
                end
            end
            if ((state_q == ST_RSP) && dbus_rsp_valid && ld_q) begin
                lsu_tx_mem    <= load_fmt;
                lsu_tx_rd_idx <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives one operation at a time, plays a simple bus,
// and checks request fields, writeback data, fault pulses and reset abort.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        lsu_rx_valid;
    logic        lsu_rx_ready;
    logic        lsu_rx_is_load;
    logic        lsu_rx_is_store;
    logic [2:0]  lsu_rx_funct3;
    logic [31:0] lsu_rx_addr;
    logic [31:0] lsu_rx_wdata;
    logic [4:0]  lsu_rx_rd_idx;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [31:0] dbus_req_addr;
    logic        dbus_req_we;
    logic [3:0]  dbus_req_wstrb;
    logic [31:0] dbus_req_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rsp_rdata;
    logic [31:0] lsu_tx_mem;
    logic        lsu_tx_mem_valid;
    logic [4:0]  lsu_tx_rd_idx;
    logic        lsu_tx_fault;
    logic [31:0] lsu_tx_fault_addr;
    logic        lsu_tx_busy;

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    logic [31:0] exp_q[$];

    lsu dut (
        .clk               (clk),
        .rst               (rst),
        .lsu_rx_valid      (lsu_rx_valid),
        .lsu_rx_ready      (lsu_rx_ready),
        .lsu_rx_is_load    (lsu_rx_is_load),
        .lsu_rx_is_store   (lsu_rx_is_store),
        .lsu_rx_funct3     (lsu_rx_funct3),
        .lsu_rx_addr       (lsu_rx_addr),
        .lsu_rx_wdata      (lsu_rx_wdata),
        .lsu_rx_rd_idx     (lsu_rx_rd_idx),
        .dbus_req_valid    (dbus_req_valid),
        .dbus_req_ready    (dbus_req_ready),
        .dbus_req_addr     (dbus_req_addr),
        .dbus_req_we       (dbus_req_we),
        .dbus_req_wstrb    (dbus_req_wstrb),
        .dbus_req_wdata    (dbus_req_wdata),
        .dbus_rsp_valid    (dbus_rsp_valid),
        .dbus_rsp_rdata    (dbus_rsp_rdata),
        .lsu_tx_mem        (lsu_tx_mem),
        .lsu_tx_mem_valid  (lsu_tx_mem_valid),
        .lsu_tx_rd_idx     (lsu_tx_rd_idx),
        .lsu_tx_fault      (lsu_tx_fault),
        .lsu_tx_fault_addr (lsu_tx_fault_addr),
        .lsu_tx_busy       (lsu_tx_busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; return just after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every writeback pulse must match the next expected load.
    always @(negedge clk) begin
        if (!rst && dbus_req_valid) req_cycles++;
        if (!rst && lsu_tx_mem_valid) begin
            if (exp_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
            else check("wb_data", lsu_tx_mem, exp_q.pop_front());
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!lsu_rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!lsu_rx_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_req(input string tag, input logic [31:0] a, input logic we,
                             input logic [3:0] ws, input logic [31:0] wd);
        check({tag, "_valid"}, {31'd0, dbus_req_valid}, 32'd1);
        check({tag, "_addr"},  dbus_req_addr, a);
        check({tag, "_we"},    {31'd0, dbus_req_we}, {31'd0, we});
        check({tag, "_wstrb"}, {28'd0, dbus_req_wstrb}, {28'd0, ws});
        if (we) check({tag, "_wdata"}, dbus_req_wdata, wd);
    endtask

    // Run one operation end to end against a bus that stalls the request
    // for wait_n cycles and answers with rdata the cycle after the handshake.
    task automatic run_op(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input int wait_n,
                          input logic exp_fault, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_mem);
        int req_before;
        wait_ready();
        req_before = req_cycles;
        lsu_rx_valid    = 1'b1;
        lsu_rx_is_load  = ld;
        lsu_rx_is_store = st;
        lsu_rx_funct3   = f3;
        lsu_rx_addr     = addr;
        lsu_rx_wdata    = wdata;
        lsu_rx_rd_idx   = rd;
        if (ld && !exp_fault) exp_q.push_back(exp_mem);
        tick();
        // Scramble the rx fields after accept: the LSU must use its latches.
        lsu_rx_valid  = 1'b0;
        lsu_rx_addr   = 32'hFFFF_FFFF;
        lsu_rx_wdata  = 32'h0;
        lsu_rx_funct3 = 3'b111;
        if (exp_fault) begin
            check({tag, "_fault"}, {31'd0, lsu_tx_fault}, 32'd1);
            check({tag, "_faddr"}, lsu_tx_fault_addr, addr);
            check({tag, "_ready_lo"}, {31'd0, lsu_rx_ready}, 32'd0);
            tick();
            check({tag, "_fault_1cyc"}, {31'd0, lsu_tx_fault}, 32'd0);
            check({tag, "_ready_back"}, {31'd0, lsu_rx_ready}, 32'd1);
            check({tag, "_faddr_held"}, lsu_tx_fault_addr, addr);
            check({tag, "_no_req"}, req_cycles - req_before, 32'd0);
            return;
        end
        check_req(tag, {addr[31:2], 2'b00}, st, exp_wstrb, exp_wdata);
        check({tag, "_busy"}, {31'd0, lsu_tx_busy}, 32'd1);
        for (int i = 0; i < wait_n; i++) begin
            tick();
            check_req({tag, "_stall"}, {addr[31:2], 2'b00}, st, exp_wstrb, exp_wdata);
        end
        dbus_req_ready = 1'b1;
        tick();
        dbus_req_ready = 1'b0;
        check({tag, "_req_drop"}, {31'd0, dbus_req_valid}, 32'd0);
        dbus_rsp_valid = 1'b1;
        dbus_rsp_rdata = rdata;
        tick();
        dbus_rsp_valid = 1'b0;
        dbus_rsp_rdata = 32'h5A5A_5A5A;
        if (ld) begin
            check({tag, "_wb_pulse"}, {31'd0, lsu_tx_mem_valid}, 32'd1);
            check({tag, "_wb_mem"}, lsu_tx_mem, exp_mem);
            check({tag, "_wb_rd"}, {27'd0, lsu_tx_rd_idx}, {27'd0, rd});
            check({tag, "_ready_wb"}, {31'd0, lsu_rx_ready}, 32'd0);
            tick();
            check({tag, "_wb_1cyc"}, {31'd0, lsu_tx_mem_valid}, 32'd0);
        end else begin
            check({tag, "_no_wb"}, {31'd0, lsu_tx_mem_valid}, 32'd0);
        end
        check({tag, "_ready_end"}, {31'd0, lsu_rx_ready}, 32'd1);
        check({tag, "_idle"}, {31'd0, lsu_tx_busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  {31'd0, lsu_rx_ready}, 32'd0);
        check({tag, "_req"},    {31'd0, dbus_req_valid}, 32'd0);
        check({tag, "_raddr"},  dbus_req_addr, 32'd0);
        check({tag, "_we"},     {31'd0, dbus_req_we}, 32'd0);
        check({tag, "_wstrb"},  {28'd0, dbus_req_wstrb}, 32'd0);
        check({tag, "_wdata"},  dbus_req_wdata, 32'd0);
        check({tag, "_mem"},    lsu_tx_mem, 32'd0);
        check({tag, "_memv"},   {31'd0, lsu_tx_mem_valid}, 32'd0);
        check({tag, "_rd"},     {27'd0, lsu_tx_rd_idx}, 32'd0);
        check({tag, "_fault"},  {31'd0, lsu_tx_fault}, 32'd0);
        check({tag, "_faddr"},  lsu_tx_fault_addr, 32'd0);
        check({tag, "_busy"},   {31'd0, lsu_tx_busy}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        lsu_rx_valid    = 1'b0;
        lsu_rx_is_load  = 1'b0;
        lsu_rx_is_store = 1'b0;
        lsu_rx_funct3   = 3'b000;
        lsu_rx_addr     = 32'h0;
        lsu_rx_wdata    = 32'h0;
        lsu_rx_rd_idx   = 5'd0;
        dbus_req_ready  = 1'b0;
        dbus_rsp_valid  = 1'b0;
        dbus_rsp_rdata  = 32'h0;

        // Reset state.
        repeat (3) tick();
        check_all_zero("rst");
        rst = 1'b0;
        tick();
        check("rst_ready_rise", {31'd0, lsu_rx_ready}, 32'd1);

        // Loads: word, signed/unsigned byte and halfword lanes.
        run_op("lw",  1, 0, 3'b010, 32'h0000_1000, 32'h0, 5'd5,  32'hDEAD_BEEF, 0, 0, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        run_op("lb",  1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd6,  32'h8012_3456, 0, 0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        run_op("lbu", 1, 0, 3'b100, 32'h0000_1003, 32'h0, 5'd7,  32'h8012_3456, 0, 0, 4'b0000, 32'h0, 32'h0000_0080);
        run_op("lh",  1, 0, 3'b001, 32'h0000_1002, 32'h0, 5'd8,  32'h8001_5678, 0, 0, 4'b0000, 32'h0, 32'hFFFF_8001);
        run_op("lhu", 1, 0, 3'b101, 32'h0000_1002, 32'h0, 5'd9,  32'h8001_5678, 2, 0, 4'b0000, 32'h0, 32'h0000_8001);
        run_op("lb1", 1, 0, 3'b000, 32'h0000_1001, 32'h0, 5'd0,  32'h0000_7F00, 0, 0, 4'b0000, 32'h0, 32'h0000_007F);

        // Stores: byte with a stalled request, halfword upper, word.
        run_op("sb",  0, 1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 5'd0, 32'h0, 3, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
        run_op("sh",  0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        run_op("sw",  0, 1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 5'd0, 32'h0, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Faults: misaligned word/halfword, both kinds set, illegal store funct3.
        run_op("f_lw",   1, 0, 3'b010, 32'h0000_1002, 32'h0, 5'd3, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
        run_op("f_sh",   0, 1, 3'b001, 32'h0000_1001, 32'h0, 5'd0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
        run_op("f_both", 1, 1, 3'b010, 32'h0000_4000, 32'h0, 5'd4, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
        run_op("f_sf3",  0, 1, 3'b100, 32'h0000_5000, 32'h0, 5'd0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);

        // Spurious response while idle is ignored.
        dbus_rsp_valid = 1'b1;
        dbus_rsp_rdata = 32'h1111_1111;
        tick();
        tick();
        dbus_rsp_valid = 1'b0;
        check("spur_ready", {31'd0, lsu_rx_ready}, 32'd1);
        check("spur_busy",  {31'd0, lsu_tx_busy}, 32'd0);
        check("spur_memv",  {31'd0, lsu_tx_mem_valid}, 32'd0);
        check("spur_req",   {31'd0, dbus_req_valid}, 32'd0);

        // Reset while waiting for a load response.
        wait_ready();
        lsu_rx_valid    = 1'b1;
        lsu_rx_is_load  = 1'b1;
        lsu_rx_is_store = 1'b0;
        lsu_rx_funct3   = 3'b010;
        lsu_rx_addr     = 32'h0000_6000;
        lsu_rx_rd_idx   = 5'd12;
        tick();
        lsu_rx_valid   = 1'b0;
        dbus_req_ready = 1'b1;
        tick();
        dbus_req_ready = 1'b0;
        check("abort_in_rsp", {31'd0, lsu_tx_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst            = 1'b0;
        dbus_rsp_valid = 1'b1;
        dbus_rsp_rdata = 32'h7777_7777;
        tick();
        dbus_rsp_valid = 1'b0;
        check("abort_ready", {31'd0, lsu_rx_ready}, 32'd1);
        check("abort_no_wb", {31'd0, lsu_tx_mem_valid}, 32'd0);
        tick();
        check("abort_no_wb2", {31'd0, lsu_tx_mem_valid}, 32'd0);
        check("abort_idle",   {31'd0, lsu_tx_busy}, 32'd0);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the GPR write port. It accepts one memory operation at a time from the EXU, checks alignment, and drives a single-outstanding request/response data bus. For loads, it aligns and sign/zero-extends the returned word and presents it as a one-cycle writeback pulse. That pulse feeds the GPR `*_rx_mem` / `*_rx_mem_valid` / `*_rx_rd_idx` inputs.

## Interface
- No parameters; data path fixed at 32 bits, 32 GPRs.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- lsu_rx_valid  in  1  EXU offers an operation
- lsu_rx_ready  out  1  LSU can accept (IDLE only)
- lsu_rx_is_load  in  1  operation is a load
- lsu_rx_is_store  in  1  operation is a store
- lsu_rx_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- lsu_rx_addr  in  32  effective byte address
- lsu_rx_wdata  in  32  store data (rs2)
- lsu_rx_rd_idx  in  5  load destination register
- dbus_req_valid  out  1  bus request valid
- dbus_req_ready  in  1  bus accepts request
- dbus_req_addr  out  32  word address ({addr[31:2],2'b00})
- dbus_req_we  out  1  1 = write
- dbus_req_wstrb  out  4  byte enables (0000 for reads)
- dbus_req_wdata  out  32  lane-replicated store data
- dbus_rsp_valid  in  1  response / write-ack valid
- dbus_rsp_rdata  in  32  read word
- lsu_tx_mem  out  32  formatted load data
- lsu_tx_mem_valid  out  1  one-cycle writeback pulse
- lsu_tx_rd_idx  out  5  writeback destination
- lsu_tx_fault  out  1  one-cycle fault pulse
- lsu_tx_fault_addr  out  32  faulting address (held until next fault)
- lsu_tx_busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, RSP, WB, FAULT.
- IDLE: lsu_rx_ready=1. On lsu_rx_valid&&ready, latch all rx fields.
  - Fault condition: is_load==is_store, an illegal funct3 for the kind, halfword with addr[0]=1, or word with addr[1:0]!=0. Fault → FAULT; otherwise → REQ.
- REQ: dbus_req_valid=1. addr/we/wstrb/wdata are stable until dbus_req_ready. Handshake → RSP.
- RSP: wait for dbus_rsp_valid. Load → capture formatted data, go to WB. Store → IDLE (rdata ignored).
- WB: lsu_tx_mem_valid=1, lsu_tx_rd_idx=latched rd. Then → IDLE. rd=0 still pulses; the GPR discards it.
- FAULT: lsu_tx_fault=1, lsu_tx_fault_addr=latched addr. No bus activity, no writeback. → IDLE.
- Store formatting (o=addr[1:0]):
  - SB: wstrb=0001<<o, wdata={4{wdata[7:0]}}.
  - SH: wstrb=o[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111.
- Load formatting: lane=rdata>>(8*o).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- dbus_rsp_valid outside RSP is ignored. dbus_req_ready outside REQ is ignored.

## Timing
- Reset: state=IDLE. Every output is 0, including lsu_rx_ready, lsu_tx_mem, lsu_tx_rd_idx and lsu_tx_fault_addr. lsu_rx_ready rises the first cycle after rst deasserts.
- Reset mid-operation aborts immediately: dbus_req_valid drops next edge, no writeback, a pending response is dropped.
- Accept at edge T → dbus_req_valid high in cycle T+1.
- A response is legal no earlier than the cycle after the request handshake.
- Best-case load (ready and rsp each zero-wait): accept T, req T+1, rsp T+2, lsu_tx_mem_valid T+3, lsu_rx_ready T+4.
- Best-case store: ready again T+3.
- Fault: pulse at T+1, ready at T+2.
- One operation outstanding. Back-to-back throughput: 4 cycles per load, 3 per store.
- Outputs are registered. No combinational path from rx to dbus or tx.

## Test plan
- LW to 0x1000, rdata=0xDEADBEEF, zero-wait bus → dbus_req_addr=0x1000, wstrb=0000, we=0. lsu_tx_mem=0xDEADBEEF with valid pulsed exactly 3 cycles after accept, rd echoed.
- LB/LBU at 0x1003, rdata=0x80xxxxxx → 0xFFFFFF80 / 0x00000080. LH at 0x1002, rdata=0x8001xxxx → 0xFFFF8001.
- SB 0xAB at 0x2001 → wstrb=0010, wdata=0xABABABAB, we=1, no writeback pulse. dbus_req_ready held low 3 cycles → request fields stable throughout.
- LW at 0x1002 and SH at 0x1001 → lsu_tx_fault pulse with fault_addr=0x1002 / 0x1001, zero dbus_req_valid cycles. is_load=is_store=1 also faults.
- rst asserted while in RSP → outputs 0 next cycle. A late dbus_rsp_valid produces no writeback. ready=1 one cycle after rst falls.
- Spurious dbus_rsp_valid in IDLE → no state change, no pulse.
